// File: rtl/v_row_loader_pkg.sv
// Shared types and constants for the V-vector FIFO producer path.
// Rows are HEAD_DIM elements of ELEM_WIDTH bits, fetched in MEM_DATA_WIDTH beats.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 16
`endif

package v_row_loader_pkg;

  localparam int HEAD_DIM        = 64;
  localparam int ELEM_WIDTH      = 8;
  localparam int MEM_DATA_WIDTH  = 64;
  localparam int MAX_SEQ_LENGTH  = `MAX_SEQ_LENGTH;
  localparam int V_ROW_BITS      = HEAD_DIM * ELEM_WIDTH;
  localparam int V_BEATS_PER_ROW = V_ROW_BITS / MEM_DATA_WIDTH;
  localparam int V_BEAT_BYTES    = MEM_DATA_WIDTH / 8;

  // Element i of a row sits at bits [i*ELEM_WIDTH +: ELEM_WIDTH].
  typedef logic [HEAD_DIM-1:0][ELEM_WIDTH-1:0] V_VECTOR_T;
  typedef logic [MEM_DATA_WIDTH-1:0]           MEM_BEAT_T;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PUSH  = 2'd2,
    DONE  = 2'd3
  } V_LOADER_STATE_T;

endpackage

// File: rtl/v_row_assembler.sv
// Beat-indexed row buffer: captures in-order read responses into slots and
// flags the cycle in which the final beat of a row lands.
module v_row_assembler
  import v_row_loader_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      capture_en_i,
  input  logic                      rsp_valid_i,
  input  logic [MEM_DATA_WIDTH-1:0] rsp_data_i,
  output logic                      row_full_o,
  output logic [V_ROW_BITS-1:0]     row_o
);

  localparam int SLOT_W = $clog2(V_BEATS_PER_ROW);
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [CNT_W-1:0] BEATS     = CNT_W'(V_BEATS_PER_ROW);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(V_BEATS_PER_ROW - 1);

  logic [V_BEATS_PER_ROW-1:0][MEM_DATA_WIDTH-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             accept_s;

  // Slot write and response counting; the counter wraps to zero on the last beat
  always_comb begin
    beats_d    = beats_q;
    rsp_cnt_d  = rsp_cnt_q;
    accept_s   = capture_en_i && rsp_valid_i && (rsp_cnt_q < BEATS);
    row_full_o = accept_s && (rsp_cnt_q == LAST_BEAT);
    if (accept_s) begin
      beats_d[rsp_cnt_q[SLOT_W-1:0]] = rsp_data_i;
      if (row_full_o) begin
        rsp_cnt_d = '0;
      end else begin
        rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
      end
    end else begin
      rsp_cnt_d = rsp_cnt_q;
    end
  end

  // Row buffer and counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      beats_q   <= '0;
      rsp_cnt_q <= '0;
    end else begin
      beats_q   <= beats_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  assign row_o = beats_q;

endmodule

// File: rtl/v_row_loader_checker.sv
// Protocol monitor: a read response is only legal while a row is being fetched
// and the row buffer still has a free slot.
module v_row_loader_checker
  import v_row_loader_pkg::*;
(
  input logic                              clock,
  input logic                              reset,
  input logic                              capture_en_i,
  input logic                              rsp_valid_i,
  input logic [$clog2(V_BEATS_PER_ROW):0]  rsp_cnt_i
);

  localparam int CNT_W = $clog2(V_BEATS_PER_ROW) + 1;

  rsp_in_fetch_window: assert property (@(posedge clock) disable iff (reset)
    rsp_valid_i |-> (capture_en_i && (rsp_cnt_i < CNT_W'(V_BEATS_PER_ROW))));

endmodule

// File: rtl/v_row_loader.sv
// Writer end of the V-vector FIFO: fetches rows_tgt contiguous V rows from memory,
// assembles each into a row and pushes it through the write_enable/sram_ready handshake.
module v_row_loader
  import v_row_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_ROWS   = MAX_SEQ_LENGTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [$clog2(NUM_ROWS):0] num_rows_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_i,
  output logic                      write_enable_o,
  input  logic                      sram_ready_i,
  output logic [V_ROW_BITS-1:0]     write_data_o
);

  localparam int ROW_W = $clog2(NUM_ROWS) + 1;
  localparam int REQ_W = $clog2(V_BEATS_PER_ROW) + 1;
  localparam logic [REQ_W-1:0]      REQ_BEATS = REQ_W'(V_BEATS_PER_ROW);
  localparam logic [ROW_W-1:0]      ROWS_MAX  = ROW_W'(NUM_ROWS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(V_BEAT_BYTES);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_PUSH  = PUSH;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]            state_q, state_d;
  logic [ROW_W-1:0]      rows_tgt_q, rows_tgt_d;
  logic [ROW_W-1:0]      row_idx_q, row_idx_d;
  logic [REQ_W-1:0]      req_cnt_q, req_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  req_valid_q, req_valid_d;
  logic                  we_q, we_d;
  logic                  req_hs_s, xfer_s, row_full_s;
  logic [ROW_W-1:0]      rows_clamp_s;
  logic [V_ROW_BITS-1:0] row_s;

  v_row_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .capture_en_i (state_q == ST_FETCH),
    .rsp_valid_i  (mem_rsp_valid_i),
    .rsp_data_i   (mem_rsp_data_i),
    .row_full_o   (row_full_s),
    .row_o        (row_s)
  );

  // Next-state logic; rows are contiguous so the address simply advances one beat per accepted request
  always_comb begin
    state_d      = state_q;
    rows_tgt_d   = rows_tgt_q;
    row_idx_d    = row_idx_q;
    req_cnt_d    = req_cnt_q;
    addr_d       = addr_q;
    req_hs_s     = req_valid_q && mem_req_ready_i;
    xfer_s       = we_q && sram_ready_i;
    rows_clamp_s = (num_rows_i > ROWS_MAX) ? ROWS_MAX : num_rows_i;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d     = base_addr_i;
          rows_tgt_d = rows_clamp_s;
          row_idx_d  = '0;
          req_cnt_d  = '0;
          state_d    = (rows_clamp_s == '0) ? ST_DONE : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (req_hs_s) begin
          req_cnt_d = req_cnt_q + REQ_W'(1);
          addr_d    = addr_q + ADDR_STEP;
        end else begin
          req_cnt_d = req_cnt_q;
        end
        if (row_full_s) begin
          req_cnt_d = '0;
          state_d   = ST_PUSH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_PUSH: begin
        if (xfer_s) begin
          row_idx_d = row_idx_q + ROW_W'(1);
          state_d   = (row_idx_q + ROW_W'(1) == rows_tgt_q) ? ST_DONE : ST_FETCH;
        end else begin
          state_d = ST_PUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_q == ST_DONE);
    req_valid_d = (state_d == ST_FETCH) && (req_cnt_d < REQ_BEATS);
    we_d        = (state_d == ST_PUSH);
  end

  // Control, counter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rows_tgt_q  <= '0;
      row_idx_q   <= '0;
      req_cnt_q   <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_tgt_q  <= rows_tgt_d;
      row_idx_q   <= row_idx_d;
      req_cnt_q   <= req_cnt_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = addr_q;
  assign write_enable_o  = we_q;
  assign write_data_o    = row_s;

endmodule

// File: tb/tb_v_row_loader.sv
// Directed bench for v_row_loader with a 2-cycle-latency memory model where byte A holds A[7:0].
module tb_v_row_loader;
  import v_row_loader_pkg::*;

  localparam int AW  = 32;
  localparam int NR  = MAX_SEQ_LENGTH;
  localparam int RW  = $clog2(NR) + 1;
  localparam int LAT = 2;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      start_i;
  logic [AW-1:0]             base_addr_i;
  logic [RW-1:0]             num_rows_i;
  logic                      busy_o, done_o;
  logic                      mem_req_valid_o, mem_req_ready_i;
  logic [AW-1:0]             mem_req_addr_o;
  logic                      mem_rsp_valid_i;
  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_i;
  logic                      write_enable_o, sram_ready_i;
  logic [V_ROW_BITS-1:0]     write_data_o;

  always #5 clock = ~clock;

  v_row_loader #(.ADDR_WIDTH(AW), .NUM_ROWS(NR)) dut (
    .clock           (clock),
    .reset           (reset),
    .start_i         (start_i),
    .base_addr_i     (base_addr_i),
    .num_rows_i      (num_rows_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .write_enable_o  (write_enable_o),
    .sram_ready_i    (sram_ready_i),
    .write_data_o    (write_data_o)
  );

  v_row_loader_checker u_chk (
    .clock        (clock),
    .reset        (reset),
    .capture_en_i (dut.u_asm.capture_en_i),
    .rsp_valid_i  (dut.u_asm.rsp_valid_i),
    .rsp_cnt_i    (dut.u_asm.rsp_cnt_q)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            c;
  } req_t;

  int                    tests_run = 0;
  int                    tests_failed = 0;
  int                    cyc = 0;
  int                    start_cyc, done_cyc, done_cnt, we_cycles, bp_cnt, stall_idx;
  bit                    stall_mode;
  logic [3:0]            stall_pat = 4'b1001;
  req_t                  pend_q[$];
  logic [AW-1:0]         req_log[$];
  logic [V_ROW_BITS-1:0] xfer_log[$];
  logic                  prev_stall, prev_bp;
  logic [AW-1:0]         prev_addr;
  logic [V_ROW_BITS-1:0] prev_data;

  task automatic check_eq(input string tag, input logic [V_ROW_BITS-1:0] obs,
                          input logic [V_ROW_BITS-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MEM_DATA_WIDTH-1:0] mem_beat(input logic [AW-1:0] a);
    logic [MEM_DATA_WIDTH-1:0] r;
    logic [AW-1:0]             t;
    for (int b = 0; b < V_BEAT_BYTES; b++) begin
      t = a + AW'(b);
      r[b*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  function automatic logic [V_ROW_BITS-1:0] exp_row(input logic [AW-1:0] row_base);
    logic [V_ROW_BITS-1:0] r;
    for (int k = 0; k < V_BEATS_PER_ROW; k++)
      r[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_beat(row_base + AW'(k * V_BEAT_BYTES));
    return r;
  endfunction

  // One clock: memory model, FIFO model and per-cycle protocol checks, all at the negedge.
  task automatic tick();
    req_t r;
    @(negedge clock);
    cyc++;
    if (reset) begin
      pend_q.delete();
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
      mem_req_ready_i = 1'b1;
      sram_ready_i    = 1'b1;
      prev_stall      = 1'b0;
      prev_bp         = 1'b0;
      return;
    end
    if (prev_stall) begin
      check_eq("addr_hold_on_stall", mem_req_addr_o, prev_addr);
      check_eq("valid_hold_on_stall", mem_req_valid_o, 1);
    end
    if (prev_bp) begin
      check_eq("we_hold_on_backpressure", write_enable_o, 1);
      check_eq("wdata_hold_on_backpressure", write_data_o, prev_data);
    end
    if (write_enable_o) begin
      we_cycles++;
      check_eq("no_req_in_push", mem_req_valid_o, 0);
    end
    if (stall_mode && mem_req_valid_o) begin
      mem_req_ready_i = stall_pat[stall_idx % 4];
      stall_idx++;
    end else begin
      mem_req_ready_i = 1'b1;
    end
    if (mem_req_valid_o && mem_req_ready_i) begin
      r.addr = mem_req_addr_o;
      r.c    = cyc;
      pend_q.push_back(r);
      req_log.push_back(mem_req_addr_o);
    end
    if (pend_q.size() > 0 && pend_q[0].c + LAT == cyc) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = mem_beat(pend_q[0].addr);
      pend_q.delete(0);
    end else begin
      mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i  = '0;
    end
    if (write_enable_o && bp_cnt > 0) begin
      sram_ready_i = 1'b0;
      bp_cnt--;
    end else begin
      sram_ready_i = 1'b1;
    end
    if (write_enable_o && sram_ready_i) xfer_log.push_back(write_data_o);
    prev_stall = mem_req_valid_o && !mem_req_ready_i;
    prev_addr  = mem_req_addr_o;
    prev_bp    = write_enable_o && !sram_ready_i;
    prev_data  = write_data_o;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      check_eq("busy_low_with_done", busy_o, 0);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    xfer_log.delete();
    done_cnt  = 0;
    we_cycles = 0;
    stall_idx = 0;
  endtask

  task automatic issue_start(input logic [AW-1:0] base, input int n);
    base_addr_i = base;
    num_rows_i  = RW'(n);
    start_i     = 1'b1;
    start_cyc   = cyc;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done_o && k < budget) begin
      tick();
      k++;
    end
    check_eq("load_completes", done_o, 1);
  endtask

  task automatic check_addrs(input logic [AW-1:0] base, input int count);
    check_eq("req_count", req_log.size(), count);
    for (int k = 0; k < req_log.size() && k < count; k++)
      check_eq("req_addr", req_log[k], base + AW'(k * V_BEAT_BYTES));
  endtask

  initial begin
    logic [V_ROW_BITS-1:0] row_v;
    reset = 1'b1; start_i = 1'b0; base_addr_i = '0; num_rows_i = '0;
    mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; sram_ready_i = 1'b1;
    stall_mode = 1'b0; bp_cnt = 0; prev_stall = 1'b0; prev_bp = 1'b0;
    clear_logs();
    repeat (3) tick();
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_req_valid", mem_req_valid_o, 0);
    check_eq("rst_req_addr", mem_req_addr_o, 0);
    check_eq("rst_we", write_enable_o, 0);
    check_eq("rst_wdata", write_data_o, 0);
    reset = 1'b0;
    tick();

    // Basic two-row load
    clear_logs();
    issue_start(32'h1000, 2);
    check_eq("busy_after_start", busy_o, 1);
    wait_done(200);
    check_addrs(32'h1000, 16);
    check_eq("basic_xfers", xfer_log.size(), 2);
    if (xfer_log.size() == 2) begin
      check_eq("basic_row0", xfer_log[0], exp_row(32'h1000));
      check_eq("basic_row1", xfer_log[1], exp_row(32'h1040));
      row_v = xfer_log[0];
      check_eq("row0_elem5", row_v[5*8 +: 8], 8'h05);
      row_v = xfer_log[1];
      check_eq("row1_elem0", row_v[7:0], 8'h40);
      check_eq("row1_elem63", row_v[63*8 +: 8], 8'h7f);
    end
    tick(); tick();
    check_eq("basic_done_once", done_cnt, 1);
    check_eq("basic_idle_busy", busy_o, 0);

    // FIFO backpressure: 5 cycles of sram_ready low in PUSH
    clear_logs();
    bp_cnt = 5;
    issue_start(32'h2000, 1);
    wait_done(200);
    check_eq("bp_xfers", xfer_log.size(), 1);
    if (xfer_log.size() == 1) check_eq("bp_row", xfer_log[0], exp_row(32'h2000));
    check_eq("bp_we_cycles", we_cycles, 6);
    check_addrs(32'h2000, 8);

    // Request stalls with ready pattern 1,0,0,1
    clear_logs();
    stall_mode = 1'b1;
    issue_start(32'h3000, 1);
    wait_done(200);
    stall_mode = 1'b0;
    check_addrs(32'h3000, 8);
    check_eq("stall_xfers", xfer_log.size(), 1);
    if (xfer_log.size() == 1) check_eq("stall_row", xfer_log[0], exp_row(32'h3000));

    // num_rows = 0
    clear_logs();
    issue_start(32'h7000, 0);
    wait_done(10);
    check_eq("zero_done_latency", done_cyc - start_cyc, 2);
    check_eq("zero_reqs", req_log.size(), 0);
    check_eq("zero_xfers", xfer_log.size(), 0);

    // num_rows above capacity clamps to NUM_ROWS
    clear_logs();
    issue_start(32'h0, NR + 5);
    wait_done(2000);
    check_eq("clamp_xfers", xfer_log.size(), NR);
    check_eq("clamp_reqs", req_log.size(), NR * V_BEATS_PER_ROW);
    if (xfer_log.size() == NR)
      check_eq("clamp_last_row", xfer_log[NR-1], exp_row(AW'((NR - 1) * 64)));

    // start while busy is ignored
    clear_logs();
    issue_start(32'h4000, 2);
    tick(); tick();
    base_addr_i = 32'h8000;
    num_rows_i  = RW'(1);
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
    wait_done(200);
    check_addrs(32'h4000, 16);
    check_eq("sb_xfers", xfer_log.size(), 2);
    repeat (4) tick();
    check_eq("sb_done_once", done_cnt, 1);
    check_eq("sb_no_restart", busy_o, 0);

    // Reset while PUSH is stalled, then a clean single-row load
    clear_logs();
    bp_cnt = 1000;
    issue_start(32'h5000, 1);
    for (int k = 0; k < 50 && !write_enable_o; k++) tick();
    check_eq("rstpush_in_push", write_enable_o, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bp_cnt = 0;
    check_eq("rstpush_we", write_enable_o, 0);
    check_eq("rstpush_busy", busy_o, 0);
    check_eq("rstpush_state", dut.state_q, 2'd0);
    tick();
    clear_logs();
    issue_start(32'h6000, 1);
    wait_done(200);
    check_addrs(32'h6000, 8);
    check_eq("post_rst_xfers", xfer_log.size(), 1);
    if (xfer_log.size() == 1) check_eq("post_rst_row", xfer_log[0], exp_row(32'h6000));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
